// File: rtl/dsi_hs_multilane.sv
// ---------------------------------------------------------------------------
// dsi_hs_multilane
//
// Multi-lane D-PHY HS transmit sequencer. A single FSM drives LANES data
// lanes through each burst: HS-go (prepare/zero), one SYNC leader byte,
// the payload words, then HS-trail. The go and trail durations can be
// programmed at runtime. When the final word is partial, the unused lanes
// start their trail pattern one cycle early.
//
// Optional feature (macro DSI_HS_UNDERFLOW_EN):
//   When defined, the block adds the output err_underflow. A missing word
//   (inp_valid=0 while the block is consuming) ends the burst with trail
//   and sets a sticky error flag. When the macro is not defined, inp_valid
//   has no effect.
//
// Ports:
//   clk_sys           in   byte clock, rising edge
//   rst_n             in   synchronous active-low reset
//   start_rqst        in   burst request, sampled in IDLE only
//   cfg_go_cycles     in   GO duration in cycles (0 acts as 1)
//   cfg_trail_cycles  in   TRAIL duration in cycles (0 acts as 1)
//   inp_data          in   payload word, byte i -> lane i
//   inp_valid         in   payload qualifier (underflow build only)
//   inp_last          in   current word is the last one of the burst
//   inp_bytes         in   valid bytes in the last word (0 or >LANES = all)
//   data_rqst         out  word consumed this cycle
//   active            out  burst in progress
//   fin_ack           out  pulse on the final TRAIL cycle
//   lane_data         out  per-lane byte to the serializer
//   lane_oe           out  per-lane HS driver enable
//   err_underflow     out  sticky underflow flag (underflow build only)
// ---------------------------------------------------------------------------
module dsi_hs_multilane #(
    parameter int           LANES     = 4,
    parameter int           CNT_W     = 8,
    parameter logic [7:0]   SYNC_BYTE = 8'h1D
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic                    start_rqst,
    input  logic [CNT_W-1:0]        cfg_go_cycles,
    input  logic [CNT_W-1:0]        cfg_trail_cycles,
    input  logic [8*LANES-1:0]      inp_data,
    input  logic                    inp_valid,
    input  logic                    inp_last,
    input  logic [$clog2(LANES):0]  inp_bytes,
    output logic                    data_rqst,
    output logic                    active,
    output logic                    fin_ack,
    output logic [8*LANES-1:0]      lane_data,
    output logic [LANES-1:0]        lane_oe
`ifdef DSI_HS_UNDERFLOW_EN
    ,
    output logic                    err_underflow
`endif
);

    localparam int BW = $clog2(LANES) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GO     = 3'd1,
        ST_SYNC   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_TRAIL  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [LANES-1:0]   last_bit_r;
    logic [LANES-1:0]   last_bit_s;
    int                 eff_bytes_s;
    logic               underflow_s;

    // Converts a programmed duration into the down-counter start value;
    // a programmed 0 behaves like 1 so the phase is never skipped.
    function automatic logic [CNT_W-1:0] dur_to_cnt(input logic [CNT_W-1:0] cfg);
        if (cfg == {CNT_W{1'b0}}) begin
            return {CNT_W{1'b0}};
        end else begin
            return cfg - CNT_W'(1'b1);
        end
    endfunction

    // HS-trail holds the inverse of the last serialised bit on the lane.
    function automatic logic [7:0] trail_byte(input logic last_bit);
        return {8{~last_bit}};
    endfunction

`ifdef DSI_HS_UNDERFLOW_EN
    logic err_r;

    assign underflow_s   = ~inp_valid;
    assign err_underflow = err_r;

    // Sticky underflow flag: cleared on reset and at the start of each burst.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start_rqst) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_ACTIVE) && underflow_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    // inp_valid only feeds this sink so the port stays harmless when the
    // underflow logic is built out; it has no effect on behaviour.
    logic unused_inp_valid;
    assign unused_inp_valid = inp_valid;
    assign underflow_s      = 1'b0;
`endif

    // Effective byte count of a final word: 0 or out-of-range means all lanes.
    always_comb begin
        if ((inp_bytes == {BW{1'b0}}) || (int'(inp_bytes) > LANES)) begin
            eff_bytes_s = LANES;
        end else begin
            eff_bytes_s = int'(inp_bytes);
        end
    end

    // State, duration counter and per-lane last-bit registers.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            last_bit_r <= {LANES{1'b0}};
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            last_bit_r <= last_bit_s;
        end
    end

    // Next-state logic and output decode from the registered state.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        last_bit_s = last_bit_r;
        data_rqst  = 1'b0;
        active     = 1'b0;
        fin_ack    = 1'b0;
        lane_data  = {(8*LANES){1'b0}};
        lane_oe    = {LANES{1'b0}};

        case (state_r)
            ST_IDLE: begin
                if (start_rqst) begin
                    state_s = ST_GO;
                    cnt_s   = dur_to_cnt(cfg_go_cycles);
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_GO: begin
                active  = 1'b1;
                lane_oe = {LANES{1'b1}};
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_SYNC;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1'b1);
                end
            end

            ST_SYNC: begin
                active  = 1'b1;
                lane_oe = {LANES{1'b1}};
                for (int i = 0; i < LANES; i++) begin
                    lane_data[8*i +: 8] = SYNC_BYTE;
                    last_bit_s[i]       = SYNC_BYTE[0];
                end
                state_s = ST_ACTIVE;
            end

            ST_ACTIVE: begin
                active    = 1'b1;
                lane_oe   = {LANES{1'b1}};
                data_rqst = 1'b1;
                if (underflow_s) begin
                    // No word available: every lane goes straight to trail.
                    for (int i = 0; i < LANES; i++) begin
                        lane_data[8*i +: 8] = trail_byte(last_bit_r[i]);
                    end
                    state_s = ST_TRAIL;
                    cnt_s   = dur_to_cnt(cfg_trail_cycles);
                end else begin
                    // Lanes beyond a partial final word begin trail early and
                    // keep their previous last bit.
                    for (int i = 0; i < LANES; i++) begin
                        if (inp_last && (i >= eff_bytes_s)) begin
                            lane_data[8*i +: 8] = trail_byte(last_bit_r[i]);
                        end else begin
                            lane_data[8*i +: 8] = inp_data[8*i +: 8];
                            last_bit_s[i]       = inp_data[8*i];
                        end
                    end
                    if (inp_last) begin
                        state_s = ST_TRAIL;
                        cnt_s   = dur_to_cnt(cfg_trail_cycles);
                    end else begin
                        state_s = ST_ACTIVE;
                    end
                end
            end

            ST_TRAIL: begin
                active  = 1'b1;
                lane_oe = {LANES{1'b1}};
                for (int i = 0; i < LANES; i++) begin
                    lane_data[8*i +: 8] = trail_byte(last_bit_r[i]);
                end
                if (cnt_r == {CNT_W{1'b0}}) begin
                    fin_ack = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1'b1);
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dsi_hs_multilane.sv
// ---------------------------------------------------------------------------
// tb_dsi_hs_multilane
//
// Directed self-checking bench for dsi_hs_multilane at LANES=4, CNT_W=8.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled on the falling edge. Observed outputs are packed as
// {active, data_rqst, fin_ack, lane_oe, lane_data}.
// ---------------------------------------------------------------------------
module tb_dsi_hs_multilane;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        start_rqst;
    logic [7:0]  cfg_go_cycles;
    logic [7:0]  cfg_trail_cycles;
    logic [31:0] inp_data;
    logic        inp_valid;
    logic        inp_last;
    logic [2:0]  inp_bytes;
    logic        data_rqst;
    logic        active;
    logic        fin_ack;
    logic [31:0] lane_data;
    logic [3:0]  lane_oe;
`ifdef DSI_HS_UNDERFLOW_EN
    logic        err_underflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    wire [38:0] obs = {active, data_rqst, fin_ack, lane_oe, lane_data};

    always #5 clk_sys = ~clk_sys;

    dsi_hs_multilane #(
        .LANES     (4),
        .CNT_W     (8),
        .SYNC_BYTE (8'h1D)
    ) dut (
        .clk_sys          (clk_sys),
        .rst_n            (rst_n),
        .start_rqst       (start_rqst),
        .cfg_go_cycles    (cfg_go_cycles),
        .cfg_trail_cycles (cfg_trail_cycles),
        .inp_data         (inp_data),
        .inp_valid        (inp_valid),
        .inp_last         (inp_last),
        .inp_bytes        (inp_bytes),
        .data_rqst        (data_rqst),
        .active           (active),
        .fin_ack          (fin_ack),
        .lane_data        (lane_data),
        .lane_oe          (lane_oe)
`ifdef DSI_HS_UNDERFLOW_EN
        ,
        .err_underflow    (err_underflow)
`endif
    );

    function automatic logic [38:0] exp_vec(input logic act, input logic rq,
                                            input logic fin, input logic [31:0] d);
        return {act, rq, fin, (act ? 4'hF : 4'h0), d};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_rqst = 1'b0; cfg_go_cycles = 8'd1; cfg_trail_cycles = 8'd1;
        inp_data = 32'h0; inp_valid = 1'b1; inp_last = 1'b0; inp_bytes = 3'd0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk_sys);
        n_tests++;
        if (obs !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, 39'h0);
        end
    endtask

    task automatic test_full_burst();
        logic [38:0] e;
        tick();
        start_rqst = 1'b1; cfg_go_cycles = 8'd3; cfg_trail_cycles = 8'd2;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            tick();
            start_rqst = 1'b0;
            inp_last = 1'b0; inp_bytes = 3'd0; inp_data = 32'h0;
            if (cyc == 5) inp_data = 32'h11223344;
            if (cyc == 6) begin inp_data = 32'hA0B1C2D3; inp_last = 1'b1; end
            case (cyc)
                1, 2, 3: e = exp_vec(1'b1, 1'b0, 1'b0, 32'h0);
                4:       e = exp_vec(1'b1, 1'b0, 1'b0, 32'h1D1D1D1D);
                5:       e = exp_vec(1'b1, 1'b1, 1'b0, 32'h11223344);
                6:       e = exp_vec(1'b1, 1'b1, 1'b0, 32'hA0B1C2D3);
                7:       e = exp_vec(1'b1, 1'b0, 1'b0, 32'hFF00FF00);
                8:       e = exp_vec(1'b1, 1'b0, 1'b1, 32'hFF00FF00);
                default: e = 39'h0;
            endcase
            @(negedge clk_sys);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL full_burst cyc%0d: got %h want %h", cyc, obs, e);
            end
        end
        inp_last = 1'b0;
    endtask

    task automatic test_partial_last();
        logic [38:0] e;
        tick();
        start_rqst = 1'b1; cfg_go_cycles = 8'd1; cfg_trail_cycles = 8'd1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            start_rqst = 1'b0;
            inp_last = 1'b0; inp_bytes = 3'd0; inp_data = 32'h0;
            if (cyc == 3) inp_data = 32'h04030201;
            if (cyc == 4) begin inp_data = 32'h777777A5; inp_last = 1'b1; inp_bytes = 3'd1; end
            case (cyc)
                1:       e = exp_vec(1'b1, 1'b0, 1'b0, 32'h0);
                2:       e = exp_vec(1'b1, 1'b0, 1'b0, 32'h1D1D1D1D);
                3:       e = exp_vec(1'b1, 1'b1, 1'b0, 32'h04030201);
                4:       e = exp_vec(1'b1, 1'b1, 1'b0, 32'hFF00FFA5);
                5:       e = exp_vec(1'b1, 1'b0, 1'b1, 32'hFF00FF00);
                default: e = 39'h0;
            endcase
            @(negedge clk_sys);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL partial_last cyc%0d: got %h want %h", cyc, obs, e);
            end
        end
        inp_last = 1'b0; inp_bytes = 3'd0;
    endtask

    task automatic test_first_last_zero_cfg();
        logic [38:0] e;
        tick();
        start_rqst = 1'b1; cfg_go_cycles = 8'd0; cfg_trail_cycles = 8'd0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            tick();
            start_rqst = 1'b0;
            inp_last = 1'b0; inp_bytes = 3'd0; inp_data = 32'h0;
            if (cyc == 3) begin inp_data = 32'h12345678; inp_last = 1'b1; inp_bytes = 3'd2; end
            case (cyc)
                1:       e = exp_vec(1'b1, 1'b0, 1'b0, 32'h0);
                2:       e = exp_vec(1'b1, 1'b0, 1'b0, 32'h1D1D1D1D);
                3:       e = exp_vec(1'b1, 1'b1, 1'b0, 32'h00005678);
                4:       e = exp_vec(1'b1, 1'b0, 1'b1, 32'h0000FFFF);
                default: e = 39'h0;
            endcase
            @(negedge clk_sys);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL first_last cyc%0d: got %h want %h", cyc, obs, e);
            end
        end
        inp_last = 1'b0; inp_bytes = 3'd0;
    endtask

    task automatic test_go_long();
        int act_cnt = 0;
        int go_cnt  = 0;
        tick();
        start_rqst = 1'b1; cfg_go_cycles = 8'd255; cfg_trail_cycles = 8'd1;
        inp_last = 1'b1; inp_bytes = 3'd0; inp_data = 32'h0;
        for (int k = 0; k < 600; k++) begin
            tick();
            start_rqst = 1'b0;
            @(negedge clk_sys);
            if (!active) break;
            act_cnt++;
            if ((lane_data == 32'h0) && !data_rqst) go_cnt++;
        end
        n_tests++;
        if (go_cnt != 255) begin
            n_fail++;
            $display("FAIL go_long_go_cycles: got %0d want %0d", go_cnt, 255);
        end
        n_tests++;
        if (act_cnt != 258) begin
            n_fail++;
            $display("FAIL go_long_active_cycles: got %0d want %0d", act_cnt, 258);
        end
        inp_last = 1'b0;
    endtask

    task automatic test_reset_mid_active();
        tick();
        start_rqst = 1'b1; cfg_go_cycles = 8'd1; cfg_trail_cycles = 8'd1;
        tick();
        start_rqst = 1'b0;
        tick();
        tick();
        inp_data = 32'hDEADBEEF; inp_last = 1'b0;
        @(negedge clk_sys);
        n_tests++;
        if (obs !== exp_vec(1'b1, 1'b1, 1'b0, 32'hDEADBEEF)) begin
            n_fail++;
            $display("FAIL mid_reset_pre: got %h want %h", obs, exp_vec(1'b1, 1'b1, 1'b0, 32'hDEADBEEF));
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk_sys);
        n_tests++;
        if (obs !== 39'h0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got %h want %h", obs, 39'h0);
        end
        tick();
        @(negedge clk_sys);
        n_tests++;
        if (obs !== 39'h0) begin
            n_fail++;
            $display("FAIL mid_reset_stay: got %h want %h", obs, 39'h0);
        end
        inp_data = 32'h0;
    endtask

    task automatic test_start_in_trail();
        tick();
        start_rqst = 1'b1; cfg_go_cycles = 8'd1; cfg_trail_cycles = 8'd2;
        tick();
        start_rqst = 1'b0;
        tick();
        tick();
        inp_data = 32'h02020202; inp_last = 1'b1; inp_bytes = 3'd0;
        tick();
        inp_last = 1'b0; inp_data = 32'h0;
        @(negedge clk_sys);
        n_tests++;
        if (obs !== exp_vec(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF)) begin
            n_fail++;
            $display("FAIL trail_first: got %h want %h", obs, exp_vec(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF));
        end
        tick();
        start_rqst = 1'b1;
        @(negedge clk_sys);
        n_tests++;
        if (obs !== exp_vec(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF)) begin
            n_fail++;
            $display("FAIL trail_final: got %h want %h", obs, exp_vec(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF));
        end
        tick();
        @(negedge clk_sys);
        n_tests++;
        if (obs !== 39'h0) begin
            n_fail++;
            $display("FAIL start_ignored_idle: got %h want %h", obs, 39'h0);
        end
        tick();
        start_rqst = 1'b0;
        @(negedge clk_sys);
        n_tests++;
        if (obs !== exp_vec(1'b1, 1'b0, 1'b0, 32'h0)) begin
            n_fail++;
            $display("FAIL restart_go: got %h want %h", obs, exp_vec(1'b1, 1'b0, 1'b0, 32'h0));
        end
        inp_last = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge clk_sys);
            if (!active) break;
        end
        n_tests++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_drain: active got %b want %b", active, 1'b0);
        end
        inp_last = 1'b0;
    endtask

`ifdef DSI_HS_UNDERFLOW_EN
    task automatic test_underflow();
        tick();
        start_rqst = 1'b1; cfg_go_cycles = 8'd1; cfg_trail_cycles = 8'd1;
        tick();
        start_rqst = 1'b0;
        tick();
        tick();
        inp_data = 32'h04030201; inp_valid = 1'b1; inp_last = 1'b0;
        tick();
        inp_data = 32'hAAAAAAAA; inp_valid = 1'b0;
        @(negedge clk_sys);
        n_tests++;
        if (obs !== exp_vec(1'b1, 1'b1, 1'b0, 32'hFF00FF00)) begin
            n_fail++;
            $display("FAIL underflow_cycle: got %h want %h", obs, exp_vec(1'b1, 1'b1, 1'b0, 32'hFF00FF00));
        end
        tick();
        inp_valid = 1'b1; inp_data = 32'h0;
        @(negedge clk_sys);
        n_tests++;
        if ({obs, err_underflow} !== {exp_vec(1'b1, 1'b0, 1'b1, 32'hFF00FF00), 1'b1}) begin
            n_fail++;
            $display("FAIL underflow_trail: got %h/%b want %h/1", obs, err_underflow, exp_vec(1'b1, 1'b0, 1'b1, 32'hFF00FF00));
        end
        tick();
        start_rqst = 1'b1;
        @(negedge clk_sys);
        n_tests++;
        if (err_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_sticky: got %b want %b", err_underflow, 1'b1);
        end
        tick();
        start_rqst = 1'b0;
        @(negedge clk_sys);
        n_tests++;
        if ({active, err_underflow} !== 2'b10) begin
            n_fail++;
            $display("FAIL underflow_clear: got %b want %b", {active, err_underflow}, 2'b10);
        end
        inp_last = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge clk_sys);
            if (!active) break;
        end
        inp_last = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_burst();
        test_partial_last();
        test_first_last_zero_cfg();
        test_go_long();
        test_reset_mid_active();
        test_start_in_trail();
`ifdef DSI_HS_UNDERFLOW_EN
        test_underflow();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsi_hs_multilane.md
Name: dsi_hs_multilane

Overview:
Parametrised multi-lane D-PHY HS transmit sequencer that drives LANES data lanes from one shared FSM. Per burst it runs HS-go (prepare/zero), then one SYNC byte, then payload, then HS-trail. Adds three things the single-lane block lacks: runtime-programmable go/trail durations, per-lane early trail when the final word is partial, and a valid-qualified input handshake. It sits between the DSI packet assembler and per-lane serializer/HS-buffer instances, which live outside this block.

Parameters:
LANES, 4, number of data lanes (1..4)
CNT_W, 8, width of the go/trail duration counters and cfg ports
SYNC_BYTE, 8'h1D, leader byte sent on every lane in SYNC

Ports:
clk_sys  in  1  byte clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
start_rqst  in  1  request an HS burst; sampled only in IDLE
cfg_go_cycles  in  CNT_W  GO duration in clk_sys cycles; 0 treated as 1
cfg_trail_cycles  in  CNT_W  TRAIL duration in cycles; 0 treated as 1
inp_data  in  8*LANES  payload word; byte i goes to lane i
inp_valid  in  1  inp_data/inp_last/inp_bytes valid
inp_last  in  1  current word is the last of the burst
inp_bytes  in  $clog2(LANES)+1  valid bytes in the last word (lanes 0..inp_bytes-1); 0 or >LANES means LANES
data_rqst  out  1  word consumed this cycle
active  out  1  burst in progress
fin_ack  out  1  one-cycle pulse on final TRAIL cycle
lane_data  out  8*LANES  per-lane byte to serializer; bit 0 is the last serialised bit
lane_oe  out  LANES  per-lane HS driver enable

Behaviour:
- Reset: synchronous. While rst_n=0 at a clock edge, state goes to IDLE, counters and last-bit registers go to 0, and error flag clears. This holds mid-burst too. On the next edge: data_rqst=0, active=0, fin_ack=0, lane_oe=0, lane_data=0.
- FSM states: IDLE, GO, SYNC, ACTIVE, TRAIL. All outputs decode combinationally from the registered state.
- IDLE: lane_data=0, lane_oe=0. If start_rqst=1, next state is GO.
- GO: lasts max(cfg_go_cycles,1) cycles, then SYNC. cfg is sampled at IDLE->GO. lane_oe=all 1, lane_data=0.
- SYNC: exactly 1 cycle, then ACTIVE. Every lane carries SYNC_BYTE. Per-lane last-bit register loads SYNC_BYTE[0].
- ACTIVE:
  - data_rqst=1 every cycle; lane i = inp_data byte i.
  - Per-lane last-bit register loads byte i bit 0 each cycle.
  - On inp_last=1, next state is TRAIL; cfg_trail_cycles is sampled on this edge.
  - Partial last word (N=inp_bytes<LANES): lanes 0..N-1 carry data. Lanes N..LANES-1 instead carry {8{~last_bit[i]}}, i.e. they start trail one cycle early and do not update last_bit.
  - inp_last on the first ACTIVE cycle: a short lane's previous byte is SYNC_BYTE, so it sends 8'h00.
- TRAIL: lasts max(cfg_trail_cycles,1) cycles, then IDLE.
  - Each lane sends {8{~last_bit[i]}}; lane_oe stays all 1.
  - fin_ack=1 in the final TRAIL cycle.
- active=1 in GO, SYNC, ACTIVE and TRAIL.
- start_rqst outside IDLE is ignored, including in the final TRAIL cycle. A new burst needs start_rqst held or re-asserted in IDLE, so there is a minimum 1 IDLE cycle between bursts.
- Counters load cfg-1 and count down to 0. Full CNT_W range is supported: 255 cycles at CNT_W=8, with no wrap.

Optional Feature:
Macro DSI_HS_UNDERFLOW_EN.
- Defined:
  - Adds output err_underflow (1 bit).
  - In ACTIVE, data_rqst=1 with inp_valid=0 is an underflow. That cycle all lanes send the trail pattern and do not update last_bit; next state is TRAIL; err_underflow sets.
  - err_underflow is sticky. It clears on reset or on the IDLE->GO transition.
- Not defined: inp_valid is ignored, the port is not connected internally, and err_underflow does not exist.

Test Plan:
- LANES=4, cfg_go=3, cfg_trail=2, start pulse, 2 full words (last on word 2):
  - active high for 3+1+2+2=8 cycles; lane_oe=4'hF throughout.
  - SYNC word 0x1D1D1D1D; fin_ack on the 8th cycle; then IDLE with lane_oe=0.
- Last word inp_bytes=1, previous word bytes 0x01,0x02,0x03,0x04:
  - last word: lanes 1..3 send 0xFF, 0x00, 0xFF while lane 0 sends data.
  - TRAIL: lane 0 sends ~bit0 of its last byte.
- inp_last on first ACTIVE cycle with inp_bytes=2 -> lanes 2,3 send 0x00 in that cycle.
- cfg_go=0 and cfg_trail=0 -> each phase lasts exactly 1 cycle. cfg_go=255 -> GO lasts 255 cycles.
- rst_n=0 for 1 cycle mid-ACTIVE -> next cycle IDLE, all outputs 0. start_rqst asserted in the final TRAIL cycle -> ignored, so GO starts no earlier than 2 edges after the last TRAIL cycle.
- DSI_HS_UNDERFLOW_EN defined, inp_valid=0 in 2nd ACTIVE cycle -> trail pattern that cycle, err_underflow=1, TRAIL follows, flag clears on next IDLE->GO.
